intersection_controller: RTL and testbench
==========================================

Name: intersection_controller

Overview:
- Sequencer for one intersection: car signal S1 (green/yellow/red) and pedestrian signal S2 (green/red).
- Runs from the 10 kHz low-frequency oscillator clock and derives its own 1 ms tick.
- Latches pedestrian requests, enforces minimum car green, yellow and all-red clearance intervals, and provides a flashing-yellow mode when disabled.
- Replaces two free-running semaphores in top level with one coordinated controller.

Parameters:
- CLK_PER_MS, 10, CLK cycles per millisecond tick.
- T_MIN_GREEN_MS, 5000, minimum S1 green before a request is served.
- T_YELLOW_MS, 2000, S1 yellow duration.
- T_ALL_RED_MS, 1000, all-red clearance, used both before and after walk.
- T_WALK_MS, 4000, S2 green duration.
- T_FLASH_MS, 500, half-period of S1 yellow blink in flash mode.

Ports:
- CLK  input  1  10 kHz clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  1 = normal sequencing, 0 = flash mode.
- ped_req  input  1  pedestrian request; any cycle high latches a request.
- ped_pending  output  1  request latched and not yet served.
- s1_green, s1_yellow, s1_red  output  1 each  car lamps.
- s2_green, s2_red  output  1 each  pedestrian lamps.
- state  output  3  current state code, for debug and verification.

Behaviour:
- States:
  - CAR_GREEN: S1 green, S2 red.
  - CAR_YELLOW: S1 yellow, S2 red.
  - CLEAR_IN: all red.
  - WALK: S1 red, S2 green.
  - CLEAR_OUT: all red.
  - FLASH: S1 blinking yellow, S2 red.
- Reset (reset=0, asynchronous): state=CLEAR_OUT, ms_cnt=0, prescaler=0, ped_pending=0, s1_red=1, s2_red=1, all other lamps 0.
- Timing:
  - Prescaler counts 0..CLK_PER_MS-1 and emits a one-cycle tick on wrap.
  - ms_cnt (16 bit) increments on each tick.
  - Both prescaler and ms_cnt clear on every state entry.
  - A timed state exits on the tick where ms_cnt == T-1, so each timed state lasts exactly T*CLK_PER_MS cycles.
- Transitions:
  - CLEAR_OUT -> CAR_GREEN after T_ALL_RED_MS.
  - CAR_GREEN -> CAR_YELLOW on the first tick where ms_cnt >= T_MIN_GREEN_MS-1 and ped_pending=1. With no request, CAR_GREEN holds indefinitely; ms_cnt saturates at all-ones.
  - CAR_YELLOW -> CLEAR_IN after T_YELLOW_MS.
  - CLEAR_IN -> WALK after T_ALL_RED_MS.
  - WALK -> CLEAR_OUT after T_WALK_MS.
  - Any state with en=0 -> FLASH on the next edge, overriding all timing.
  - FLASH with en=1 -> CLEAR_OUT.
- Request latch:
  - ped_pending sets on ped_req=1 in CAR_GREEN, CAR_YELLOW, CLEAR_OUT or FLASH.
  - ped_req is ignored in CLEAR_IN and WALK.
  - ped_pending clears on the edge entering WALK; clear has priority over set.
  - ped_pending survives FLASH.
- FLASH mode:
  - s1_yellow=1 on entry, toggles every T_FLASH_MS.
  - s1_green=s1_red=0, s2_red=1, s2_green=0.
- Lamp outputs:
  - Registered, decoded from the next state, so lamps change on the same edge as state.
  - Exactly one S1 lamp is on outside FLASH; exactly one S2 lamp is on at all times.
  - s1_green and s2_green are never both 1.
- state encoding is stable and defined in the package.

Decomposition:
- Package intersection_pkg holds:
  - state enum codes: CAR_GREEN=0, CAR_YELLOW=1, CLEAR_IN=2, WALK=3, CLEAR_OUT=4, FLASH=5;
  - the lamp-vector constant per state;
  - the ms_cnt width constant.
- Sub-module ms_tick_gen (prescaler with synchronous clear input and tick output), instantiated once.

Test Plan:
Overrides for all tests: CLK_PER_MS=2, T_MIN_GREEN_MS=8, T_YELLOW_MS=3, T_ALL_RED_MS=2, T_WALK_MS=5, T_FLASH_MS=4.
- Reset release, en=1, no request -> all-red for 4 cycles, then s1_green=1 and held for 200 cycles with no s1_yellow.
- ped_req pulse 2 cycles into CAR_GREEN -> ped_pending=1 next cycle; green lasts 16 cycles total, yellow 6, all-red 4, s2_green 10 (ped_pending drops at WALK entry), all-red 4, then s1_green.
- ped_req pulse 20 cycles into CAR_GREEN (past minimum) -> s1_yellow asserted within 3 cycles of the pulse.
- ped_req pulsed during WALK -> ignored; after CLEAR_OUT, CAR_GREEN holds 200 cycles with ped_pending=0.
- en=0 mid-WALK -> next edge s2_green=0, s2_red=1, s1_yellow=1, toggling every 8 cycles. en=1 -> all-red 4 cycles, then s1_green.
- reset=0 mid-CAR_YELLOW between clock edges -> s1_red=1, s2_red=1, ped_pending=0 immediately, without a clock edge.
- Throughout all tests, a monitor checks the lamp invariants: exactly one S2 lamp on; exactly one S1 lamp outside FLASH; s1_green and s2_green never both on.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection controller: state codes, lamp
// vectors per state and counter widths.
package intersection_pkg;

   localparam int unsigned MS_CNT_W = 16;
   localparam int unsigned STATE_W  = 3;

   // Encoding is visible on the debug port and must stay stable.
   typedef enum logic [STATE_W-1:0] {
      CAR_GREEN  = 3'd0,
      CAR_YELLOW = 3'd1,
      CLEAR_IN   = 3'd2,
      WALK       = 3'd3,
      CLEAR_OUT  = 3'd4,
      FLASH      = 3'd5
   } state_t;

   typedef struct packed {
      logic s1_green;
      logic s1_yellow;
      logic s1_red;
      logic s2_green;
      logic s2_red;
   } lamps_t;

   localparam lamps_t LAMPS_CAR_GREEN  = lamps_t'(5'b10001);
   localparam lamps_t LAMPS_CAR_YELLOW = lamps_t'(5'b01001);
   localparam lamps_t LAMPS_ALL_RED    = lamps_t'(5'b00101);
   localparam lamps_t LAMPS_WALK       = lamps_t'(5'b00110);
   // FLASH lit phase; the dark phase clears s1_yellow.
   localparam lamps_t LAMPS_FLASH      = lamps_t'(5'b01001);

   function automatic lamps_t lamps_of(input state_t s);
      lamps_t l;
      case (s)
         CAR_GREEN:  l = LAMPS_CAR_GREEN;
         CAR_YELLOW: l = LAMPS_CAR_YELLOW;
         CLEAR_IN:   l = LAMPS_ALL_RED;
         WALK:       l = LAMPS_WALK;
         CLEAR_OUT:  l = LAMPS_ALL_RED;
         FLASH:      l = LAMPS_FLASH;
         default:    l = LAMPS_ALL_RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CLK_PER_MS-1 and flags the wrap cycle.
// Ports: CLK, reset (async active-low), clr (sync restart), tick_c (wrap flag).
module ms_tick_gen #(
   parameter int unsigned CLK_PER_MS = 10
) (
   input  logic CLK,
   input  logic reset,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);

   logic [PRESC_W-1:0] presc;

   assign tick_c = (presc == PRESC_MAX);

   // Prescaler with restart on clr and wrap at PRESC_MAX.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (clr || (presc == PRESC_MAX)) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/intersection_controller.sv
// Coordinated car (S1) / pedestrian (S2) signal sequencer with latched
// pedestrian requests, timed intervals and a flashing-yellow disabled mode.
// Ports: CLK, reset (async active-low), en (0 = flash mode), ped_req,
//        ped_pending, s1_green/s1_yellow/s1_red, s2_green/s2_red, state (debug).
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int unsigned CLK_PER_MS     = 10,
   parameter int unsigned T_MIN_GREEN_MS = 5000,
   parameter int unsigned T_YELLOW_MS    = 2000,
   parameter int unsigned T_ALL_RED_MS   = 1000,
   parameter int unsigned T_WALK_MS      = 4000,
   parameter int unsigned T_FLASH_MS     = 500
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               en,
   input  logic               ped_req,
   output logic               ped_pending,
   output logic               s1_green,
   output logic               s1_yellow,
   output logic               s1_red,
   output logic               s2_green,
   output logic               s2_red,
   output logic [STATE_W-1:0] state
);

   // Terminal ms_cnt values; an interval ends on the tick seen at T-1.
   localparam logic [MS_CNT_W-1:0] MIN_GREEN_LAST = MS_CNT_W'(T_MIN_GREEN_MS - 1);
   localparam logic [MS_CNT_W-1:0] YELLOW_LAST    = MS_CNT_W'(T_YELLOW_MS - 1);
   localparam logic [MS_CNT_W-1:0] ALL_RED_LAST   = MS_CNT_W'(T_ALL_RED_MS - 1);
   localparam logic [MS_CNT_W-1:0] WALK_LAST      = MS_CNT_W'(T_WALK_MS - 1);
   localparam logic [MS_CNT_W-1:0] FLASH_LAST     = MS_CNT_W'(T_FLASH_MS - 1);
   localparam logic [MS_CNT_W-1:0] MS_CNT_MAX     = '1;

   state_t              state_q;
   state_t              state_nxt_c;
   logic                tick_c;
   logic                entry_c;
   logic                flash_flip_c;
   logic [MS_CNT_W-1:0] ms_cnt;
   logic [MS_CNT_W-1:0] ms_cnt_nxt_c;
   logic                flash_y;
   logic                flash_y_nxt_c;
   logic                pend_nxt_c;
   lamps_t              lamps_q;
   lamps_t              lamps_nxt_c;

   ms_tick_gen #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_ms_tick_gen (
      .CLK    (CLK),
      .reset  (reset),
      .clr    (entry_c),
      .tick_c (tick_c)
   );

   // State register.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q <= CLEAR_OUT;
      end else begin
         state_q <= state_nxt_c;
      end
   end

   // Next-state logic; en=0 overrides all timing.
   always_comb begin
      state_nxt_c = state_q;
      if (!en) begin
         state_nxt_c = FLASH;
      end else begin
         case (state_q)
            CLEAR_OUT:  if (tick_c && (ms_cnt == ALL_RED_LAST)) state_nxt_c = CAR_GREEN;
            CAR_GREEN:  if (tick_c && (ms_cnt >= MIN_GREEN_LAST) && ped_pending)
                           state_nxt_c = CAR_YELLOW;
            CAR_YELLOW: if (tick_c && (ms_cnt == YELLOW_LAST))  state_nxt_c = CLEAR_IN;
            CLEAR_IN:   if (tick_c && (ms_cnt == ALL_RED_LAST)) state_nxt_c = WALK;
            WALK:       if (tick_c && (ms_cnt == WALK_LAST))    state_nxt_c = CLEAR_OUT;
            FLASH:      state_nxt_c = CLEAR_OUT;
            default:    state_nxt_c = CLEAR_OUT;
         endcase
      end
   end

   // Output / datapath next values: timer, flash phase, request latch, lamps.
   always_comb begin
      entry_c       = (state_nxt_c != state_q);
      flash_flip_c  = (state_q == FLASH) && tick_c && (ms_cnt == FLASH_LAST);
      ms_cnt_nxt_c  = ms_cnt;
      flash_y_nxt_c = flash_y;
      pend_nxt_c    = ped_pending;
      lamps_nxt_c   = lamps_of(state_nxt_c);

      // Flash mode reuses ms_cnt as its half-period timer.
      if (entry_c || flash_flip_c) begin
         ms_cnt_nxt_c = '0;
      end else if (tick_c && (ms_cnt != MS_CNT_MAX)) begin
         ms_cnt_nxt_c = ms_cnt + MS_CNT_W'(1);
      end

      // Yellow starts lit on every FLASH entry.
      if (entry_c) begin
         flash_y_nxt_c = 1'b1;
      end else if (flash_flip_c) begin
         flash_y_nxt_c = ~flash_y;
      end

      // Entering WALK serves the request; that clear wins over a new set.
      if (entry_c && (state_nxt_c == WALK)) begin
         pend_nxt_c = 1'b0;
      end else if (ped_req && (state_q != CLEAR_IN) && (state_q != WALK)) begin
         pend_nxt_c = 1'b1;
      end

      if (state_nxt_c == FLASH) begin
         lamps_nxt_c.s1_yellow = flash_y_nxt_c;
      end
   end

   // Registered datapath and lamps, decoded from next state.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         ms_cnt      <= '0;
         flash_y     <= 1'b1;
         ped_pending <= 1'b0;
         lamps_q     <= LAMPS_ALL_RED;
      end else begin
         ms_cnt      <= ms_cnt_nxt_c;
         flash_y     <= flash_y_nxt_c;
         ped_pending <= pend_nxt_c;
         lamps_q     <= lamps_nxt_c;
      end
   end

   assign s1_green  = lamps_q.s1_green;
   assign s1_yellow = lamps_q.s1_yellow;
   assign s1_red    = lamps_q.s1_red;
   assign s2_green  = lamps_q.s2_green;
   assign s2_red    = lamps_q.s2_red;
   assign state     = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench for intersection_controller: a phase/elapsed-cycle model
// predicts every cycle's outputs; a negedge monitor compares and checks lamp
// invariants.
module tb_intersection_controller;

   localparam int N   = 2;
   localparam int TMG = 8;
   localparam int TY  = 3;
   localparam int TAR = 2;
   localparam int TW  = 5;
   localparam int TF  = 4;

   localparam int PH_GREEN  = 0;
   localparam int PH_YELLOW = 1;
   localparam int PH_CIN    = 2;
   localparam int PH_WALK   = 3;
   localparam int PH_COUT   = 4;
   localparam int PH_FLASH  = 5;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b1;
   logic       ped_req = 1'b0;
   logic       ped_pending;
   logic       s1_green, s1_yellow, s1_red, s2_green, s2_red;
   logic [2:0] state;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] exp_q[$];

   int m_phase = PH_COUT;
   int m_cyc   = 0;
   int m_nxt   = PH_COUT;
   bit m_pend  = 1'b0;
   bit m_tick  = 1'b0;

   intersection_controller #(
      .CLK_PER_MS     (N),
      .T_MIN_GREEN_MS (TMG),
      .T_YELLOW_MS    (TY),
      .T_ALL_RED_MS   (TAR),
      .T_WALK_MS      (TW),
      .T_FLASH_MS     (TF)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .en          (en),
      .ped_req     (ped_req),
      .ped_pending (ped_pending),
      .s1_green    (s1_green),
      .s1_yellow   (s1_yellow),
      .s1_red      (s1_red),
      .s2_green    (s2_green),
      .s2_red      (s2_red),
      .state       (state)
   );

   always #5 CLK = ~CLK;

   // Lamps {s1g,s1y,s1r,s2g,s2r} for a phase, cyc cycles after entering it.
   function automatic logic [4:0] lamp_ref(input int ph, input int cyc);
      case (ph)
         PH_GREEN:  return 5'b10001;
         PH_YELLOW: return 5'b01001;
         PH_WALK:   return 5'b00110;
         PH_FLASH:  return (((cyc / (TF * N)) % 2) == 0) ? 5'b01001 : 5'b00001;
         default:   return 5'b00101;
      endcase
   endfunction

   // Reference model: phases measured in elapsed cycles since entry.
   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         m_phase = PH_COUT;
         m_cyc   = 0;
         m_pend  = 1'b0;
         exp_q.delete();
      end else begin
         m_tick = ((m_cyc % N) == N - 1);
         m_nxt  = m_phase;
         if (!en) begin
            m_nxt = PH_FLASH;
         end else begin
            case (m_phase)
               PH_COUT:   if (m_cyc + 1 >= TAR * N) m_nxt = PH_GREEN;
               PH_GREEN:  if (m_tick && (m_cyc + 1 >= TMG * N) && m_pend) m_nxt = PH_YELLOW;
               PH_YELLOW: if (m_cyc + 1 >= TY * N) m_nxt = PH_CIN;
               PH_CIN:    if (m_cyc + 1 >= TAR * N) m_nxt = PH_WALK;
               PH_WALK:   if (m_cyc + 1 >= TW * N) m_nxt = PH_COUT;
               default:   m_nxt = PH_COUT;
            endcase
         end
         if (m_nxt == PH_WALK && m_phase != PH_WALK) m_pend = 1'b0;
         else if (ped_req && m_phase != PH_CIN && m_phase != PH_WALK) m_pend = 1'b1;
         m_cyc   = (m_nxt != m_phase) ? 0 : m_cyc + 1;
         m_phase = m_nxt;
         exp_q.push_back({3'(m_phase), m_pend, lamp_ref(m_phase, m_cyc)});
      end
   end

   // Monitor: per-cycle scoreboard compare plus lamp invariants.
   logic [8:0] got_v, exp_v;
   always @(negedge CLK) begin
      if (reset) begin
         got_v = {state, ped_pending, s1_green, s1_yellow, s1_red, s2_green, s2_red};
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (got_v !== exp_v) begin
               n_errors++;
               $display("FAIL cycle_match t=%0t got state=%0d pend=%b lamps=%b required state=%0d pend=%b lamps=%b",
                        $time, got_v[8:6], got_v[5], got_v[4:0], exp_v[8:6], exp_v[5], exp_v[4:0]);
            end
         end
         n_checks++;
         if ((32'(s2_green) + 32'(s2_red)) != 1) begin
            n_errors++;
            $display("FAIL s2_one_hot t=%0t got s2_green=%b s2_red=%b required exactly one", $time, s2_green, s2_red);
         end
         n_checks++;
         if (state != 3'd5 && (32'(s1_green) + 32'(s1_yellow) + 32'(s1_red)) != 1) begin
            n_errors++;
            $display("FAIL s1_one_hot t=%0t got s1=%b%b%b required exactly one", $time, s1_green, s1_yellow, s1_red);
         end
         n_checks++;
         if (s1_green && s2_green) begin
            n_errors++;
            $display("FAIL green_conflict t=%0t got both greens on required not both", $time);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse();
      ped_req = 1'b1;
      @(negedge CLK);
      ped_req = 1'b0;
   endtask

   // Bounded wait for a lamp: 0 = s2_green, 1 = s1_yellow, 2 = s1_green.
   task automatic wait_for(input int which, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         case (which)
            0:       seen = s2_green;
            1:       seen = s1_yellow;
            default: seen = s1_green;
         endcase
         if (!seen) @(negedge CLK);
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_timeout lamp=%0d got not asserted within %0d cycles required asserted", which, limit);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if ({state, ped_pending, s1_green, s1_yellow, s1_red, s2_green, s2_red} !== 9'b100_0_00101) begin
         n_errors++;
         $display("FAIL %s got state=%0d pend=%b lamps=%b%b%b%b%b required state=4 pend=0 lamps=00101",
                  name, state, ped_pending, s1_green, s1_yellow, s1_red, s2_green, s2_red);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no finish required finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset_outputs("reset_state");
      @(negedge CLK);
      reset = 1'b1;

      // Idle: all-red then green held with no request.
      cyc(220);

      // Request two cycles into green: full pedestrian cycle.
      reset = 1'b0;
      @(negedge CLK);
      reset = 1'b1;
      cyc(4);
      cyc(2);
      pulse();
      cyc(60);

      // Request well past minimum green.
      wait_for(2, 100);
      cyc(20);
      pulse();
      cyc(40);

      // Request during WALK is ignored.
      pulse();
      wait_for(0, 100);
      cyc(2);
      pulse();
      cyc(230);

      // Disable mid-WALK, flash, then re-enable.
      pulse();
      wait_for(0, 100);
      cyc(3);
      en = 1'b0;
      cyc(40);
      en = 1'b1;
      cyc(30);

      // Randomized requests and enable changes.
      for (int i = 0; i < 1500; i++) begin
         ped_req = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 199) == 0) en = ~en;
         @(negedge CLK);
      end
      en = 1'b1;
      ped_req = 1'b0;
      cyc(30);

      // Asynchronous reset mid-yellow, between clock edges.
      pulse();
      wait_for(1, 100);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge CLK);
      reset = 1'b1;
      cyc(30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
